// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: drives the PLL reset, qualifies the asynchronous lock
// output, retries on lock timeout and gives up after a retry limit. Produces
// the core reset/ready flags plus status counters.
// Build option: define PLL_SUP_GLITCH_FILTER_EN to require 3 consecutive
// unlocked cycles in RUN before a lock loss is declared.
// state_dbg exposes the FSM state (encoding of state_t) for debug/checkers.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int MAX_RETRIES      = 7
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       clear_stats,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state_dbg
);

  localparam int MAX_TS  = (LOCK_TIMEOUT_CYC > LOCK_STABLE_CYC) ? LOCK_TIMEOUT_CYC : LOCK_STABLE_CYC;
  localparam int MAX_CYC = (MAX_TS > RST_PULSE_CYC) ? MAX_TS : RST_PULSE_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       lol_q, lol_d;
  logic [1:0]       sync_q, sync_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             locked_s;
  logic             loss_evt;
  logic             lol_inc;

  // Two-flop synchronizer for the asynchronous PLL lock flag.
  always_comb begin
    sync_d = {sync_q[0], locked};
  end

  assign locked_s = sync_q[1];

`ifdef PLL_SUP_GLITCH_FILTER_EN
  logic [1:0] filt_q, filt_d;

  // Count consecutive unlocked cycles in RUN; any locked cycle restarts it.
  always_comb begin
    filt_d = 2'd0;
    if (state_q == ST_RUN && !locked_s) begin
      filt_d = (filt_q == 2'd2) ? filt_q : filt_q + 2'd1;
    end
  end

  assign loss_evt = (state_q == ST_RUN) && !locked_s && (filt_q == 2'd2);

  // Glitch filter counter register.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) filt_q <= 2'd0;
    else        filt_q <= filt_d;
  end
`else
  assign loss_evt = (state_q == ST_RUN) && !locked_s;
`endif

  // Next-state, cycle counter and retry bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    lol_inc = 1'b0;
    case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock wins over a coincident timeout.
        if (locked_s) begin
          state_d = ST_STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_q + 4'd1;
          state_d = (retry_d == RETRY_LIMIT) ? ST_FAIL : ST_RESET_PLL;
          cnt_d   = '0;
        end
      end
      ST_STABILIZE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (loss_evt) begin
          state_d = ST_RESET_PLL;
          retry_d = 4'd0;
          lol_inc = 1'b1;
        end
      end
      ST_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_RESET_PLL;
        cnt_d   = '0;
      end
    endcase
  end

  // Lock-loss statistics: saturating increment, clear leaves a coincident event counted.
  always_comb begin
    lol_d = lol_q;
    if (clear_stats) begin
      lol_d = lol_inc ? 8'd1 : 8'd0;
    end else if (lol_inc && lol_q != 8'hFF) begin
      lol_d = lol_q + 8'd1;
    end
  end

  // Registered outputs decoded from the next state so they change on state entry.
  always_comb begin
    pll_rst_d   = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
    sys_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

  // State, counters, synchronizer and output registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= 4'd0;
      lol_q       <= 8'd0;
      sync_q      <= 2'b00;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lol_q       <= lol_d;
      sync_q      <= sync_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign ready         = ready_q;
  assign fail          = fail_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = lol_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor. The output vector
// {pll_rst, sys_rst_n, ready, fail, retry_cnt, lock_loss_cnt} is watched at
// every falling edge; each change pops the next expected {edge, vector} entry,
// which the driver pushes (hand-computed edge numbers) when it issues stimulus.
module tb_pll_lock_supervisor;

`ifdef PLL_SUP_GLITCH_FILTER_EN
  localparam int F    = 2;
  localparam bit FILT = 1'b1;
`else
  localparam int F    = 0;
  localparam bit FILT = 1'b0;
`endif

  localparam int W = 48;
  localparam logic [15:0] RST_VEC = 16'h8000;

  logic       refclk;
  logic       rst_n;
  logic       locked;
  logic       clear_stats;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state_dbg;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [7:0]   exp_lol = 8'd0;
  logic [15:0]  prev_v = RST_VEC;

  pll_lock_supervisor #(
    .RST_PULSE_CYC   (4),
    .LOCK_STABLE_CYC (8),
    .LOCK_TIMEOUT_CYC(32),
    .MAX_RETRIES     (2)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .locked       (locked),
    .clear_stats  (clear_stats),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .fail         (fail),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  always @(posedge refclk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, exp_q.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [15:0] mk(input bit p, input bit s, input bit r, input bit f,
                                     input logic [3:0] rc, input logic [7:0] lc);
    return {p, s, r, f, rc, lc};
  endfunction

  task automatic push(input int edge_n, input logic [15:0] v);
    exp_q.push_back({32'(edge_n), v});
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge refclk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge refclk) begin
    logic [15:0]  cur_v;
    logic [W-1:0] e;
    cur_v = {pll_rst, sys_rst_n, ready, fail, retry_cnt, lock_loss_cnt};
    if (cur_v !== prev_v) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change edge=%0d got=%h", cyc, cur_v);
      end else begin
        e = exp_q.pop_front();
        if (e[15:0] !== cur_v || e[47:16] !== 32'(cyc)) begin
          errors++;
          $display("FAIL output_change got edge=%0d vec=%h exp edge=%0d vec=%h",
                   cyc, cur_v, e[47:16], e[15:0]);
        end
      end
      prev_v = cur_v;
    end
  end

  // ---------------- driver tasks ----------------
  // Long drop from RUN: lock loss, PLL re-reset, re-lock, RUN again.
  task automatic run_loss(input bit clr);
    int c;
    int l;
    c = cyc;
    l = c + 3 + F;
    exp_lol = clr ? 8'd1 : ((exp_lol == 8'hFF) ? 8'hFF : 8'(exp_lol + 8'd1));
    locked = 1'b0;
    push(l,      mk(1, 0, 0, 0, 4'd0, exp_lol));
    push(l + 4,  mk(0, 0, 0, 0, 4'd0, exp_lol));
    push(l + 13, mk(0, 1, 1, 0, 4'd0, exp_lol));
    if (clr) begin
      wait_until(l - 1);
      clear_stats = 1'b1;
      wait_until(l);
      clear_stats = 1'b0;
    end
    wait_until(c + 5);
    locked = 1'b1;
    wait_until(l + 15);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int l;
    int d;
    int e;
    int r;
    locked      = 1'b0;
    clear_stats = 1'b0;
    rst_n       = 1'b1;
    #1 rst_n    = 1'b0;
    wait_until(3);

    // reset values
    chk("rst_pll_rst",   32'(pll_rst), 32'd1);
    chk("rst_sys_rst_n", 32'(sys_rst_n), 32'd0);
    chk("rst_ready",     32'(ready), 32'd0);
    chk("rst_fail",      32'(fail), 32'd0);
    chk("rst_retry",     32'(retry_cnt), 32'd0);
    chk("rst_lol",       32'(lock_loss_cnt), 32'd0);
    chk("rst_state",     32'(state_dbg), 32'd0);

    // clean bring-up
    c = cyc;
    rst_n = 1'b1;
    push(c + 4, mk(0, 0, 0, 0, 4'd0, 8'd0));
    wait_until(c + 9);
    locked = 1'b1;
    c = cyc;
    push(c + 11, mk(0, 1, 1, 0, 4'd0, 8'd0));
    wait_until(c + 13);

    // lock loss in RUN
    run_loss(1'b0);

    // single-cycle glitch
    c = cyc;
    locked = 1'b0;
    wait_until(c + 1);
    locked = 1'b1;
    if (!FILT) begin
      l = c + 3;
      exp_lol = 8'(exp_lol + 8'd1);
      push(l,      mk(1, 0, 0, 0, 4'd0, exp_lol));
      push(l + 4,  mk(0, 0, 0, 0, 4'd0, exp_lol));
      push(l + 13, mk(0, 1, 1, 0, 4'd0, exp_lol));
    end
    wait_until(c + 20);

    // loss, one timeout, stabilize abort, then stable lock
    c = cyc;
    l = c + 3 + F;
    locked = 1'b0;
    exp_lol = 8'(exp_lol + 8'd1);
    push(l,      mk(1, 0, 0, 0, 4'd0, exp_lol));
    push(l + 4,  mk(0, 0, 0, 0, 4'd0, exp_lol));
    push(l + 36, mk(1, 0, 0, 0, 4'd1, exp_lol));
    push(l + 40, mk(0, 0, 0, 0, 4'd1, exp_lol));
    wait_until(l + 40);
    d = cyc;
    locked = 1'b1;
    wait_until(d + 5);
    locked = 1'b0;
    wait_until(d + 10);
    locked = 1'b1;
    e = cyc;
    push(e + 11, mk(0, 1, 1, 0, 4'd1, exp_lol));
    wait_until(e + 13);

    // clear_stats coincident with a loss increment
    run_loss(1'b1);

    // saturation
    for (int i = 0; i < 300; i++) run_loss(1'b0);

    // clear_stats on its own
    c = cyc;
    clear_stats = 1'b1;
    exp_lol = 8'd0;
    push(c + 1, mk(0, 1, 1, 0, 4'd0, 8'd0));
    wait_until(c + 1);
    clear_stats = 1'b0;
    wait_until(c + 3);

    // async reset mid-STABILIZE
    c = cyc;
    l = c + 3 + F;
    locked = 1'b0;
    exp_lol = 8'd1;
    push(l,     mk(1, 0, 0, 0, 4'd0, 8'd1));
    push(l + 4, mk(0, 0, 0, 0, 4'd0, 8'd1));
    wait_until(l + 4);
    d = cyc;
    locked = 1'b1;
    wait_until(d + 5);
    push(d + 6, RST_VEC);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pll_rst",   32'(pll_rst), 32'd1);
    chk("arst_sys_rst_n", 32'(sys_rst_n), 32'd0);
    chk("arst_ready",     32'(ready), 32'd0);
    chk("arst_lol",       32'(lock_loss_cnt), 32'd0);
    chk("arst_state",     32'(state_dbg), 32'd0);
    locked = 1'b0;
    exp_lol = 8'd0;
    wait_until(d + 8);

    // timeout, retry, hard fail
    r = cyc;
    rst_n = 1'b1;
    push(r + 4,  mk(0, 0, 0, 0, 4'd0, 8'd0));
    push(r + 36, mk(1, 0, 0, 0, 4'd1, 8'd0));
    push(r + 40, mk(0, 0, 0, 0, 4'd1, 8'd0));
    push(r + 72, mk(1, 0, 0, 1, 4'd2, 8'd0));
    wait_until(r + 75);
    chk("fail_flag", 32'(fail), 32'd1);
    locked = 1'b1;
    wait_until(r + 95);
    for (int i = 0; i < 6; i++) begin
      locked = ~locked;
      wait_until(cyc + 3);
    end
    wait_until(cyc + 5);
    chk("fail_sticky",  32'(fail), 32'd1);
    chk("fail_pll_rst", 32'(pll_rst), 32'd1);
    chk("queue_empty",  32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
